// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronized rx, start verified at half bit, MSB-first data, one stop bit.
// Build macro RX_MAJORITY_VOTE_EN: each decision is the 2-of-3 majority of the last three rx_s.
`ifndef WORD_SIZE_p
`define WORD_SIZE_p 8
`endif
`ifndef CLOCK_FREQ_p
`define CLOCK_FREQ_p 50000000
`endif
`ifndef BAUD_RATE_p
`define BAUD_RATE_p 115200
`endif

module uart_receiver #(
    parameter int unsigned WORD_SIZE  = `WORD_SIZE_p,
    parameter int unsigned CLOCK_FREQ = `CLOCK_FREQ_p,
    parameter int unsigned BAUD_RATE  = `BAUD_RATE_p
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rx_read_i,
    output logic [WORD_SIZE-1:0] data_recv,
    output logic                 rx_avbl_o,
    output logic                 rx_frame_err_o,
    output logic                 rx_overrun_o,
    output logic                 rx_busy_o
);
    localparam int unsigned BIT_CLKS = CLOCK_FREQ / BAUD_RATE + 1;
    localparam int unsigned HALF     = BIT_CLKS / 2;
    localparam int unsigned BW       = $clog2(WORD_SIZE) + 1;

    localparam logic [15:0]   HalfLast = 16'(HALF - 1);
    localparam logic [15:0]   BitLast  = 16'(BIT_CLKS - 1);
    localparam logic [BW-1:0] LastBit  = BW'(WORD_SIZE - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e               state_q;
    logic [1:0]           sync_q;
    logic                 rx_s;
    logic [15:0]          baud_q;
    logic [BW-1:0]        bit_q;
    logic [WORD_SIZE-1:0] shift_q;
    logic [WORD_SIZE-1:0] data_q;
    logic                 avbl_q;
    logic                 ferr_q;
    logic                 ovr_q;
    logic                 busy_q;
    logic                 sample;

    assign rx_s = sync_q[1];

`ifdef RX_MAJORITY_VOTE_EN
    // Samples from decision counter -2 and -1; the counter advances every cycle up to a decision.
    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);

    if (BIT_CLKS < 6) begin : g_bit_clks_check
        $error("uart_receiver: majority vote needs BIT_CLKS >= 6");
    end
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sync_q  <= 2'b11;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            avbl_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx};
            ferr_q <= 1'b0;
            if (rx_read_i && avbl_q) begin
                avbl_q <= 1'b0;
                ovr_q  <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_q <= StStart;
                        baud_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StStart: begin
                    if (baud_q == HalfLast) begin
                        if (!sample) begin
                            state_q <= StData;
                            baud_q  <= '0;
                            bit_q   <= '0;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                StData: begin
                    if (baud_q == BitLast) begin
                        shift_q <= {shift_q[WORD_SIZE-2:0], sample};
                        baud_q  <= '0;
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == LastBit) begin
                            state_q <= StStop;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                StStop: begin
                    if (baud_q == BitLast) begin
                        baud_q <= '0;
                        if (sample) begin
                            data_q  <= shift_q;
                            avbl_q  <= 1'b1;
                            // A same-cycle read consumes the old word, so no overrun.
                            ovr_q   <= avbl_q && !rx_read_i;
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= StBreak;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                StBreak: begin
                    if (rx_s) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_recv      = data_q;
    assign rx_avbl_o      = avbl_q;
    assign rx_frame_err_o = ferr_q;
    assign rx_overrun_o   = ovr_q;
    assign rx_busy_o      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: 16 clocks per bit, scoreboard of expected words.
module tb_uart_receiver;
    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_read_i;
    logic [7:0] data_recv;
    logic       rx_avbl_o;
    logic       rx_frame_err_o;
    logic       rx_overrun_o;
    logic       rx_busy_o;

    int checks   = 0;
    int failures = 0;
    int ferr_cnt = 0;
    logic [7:0] exp_q[$];

`ifdef RX_MAJORITY_VOTE_EN
    localparam bit Glitch = 1'b1;
`else
    localparam bit Glitch = 1'b0;
`endif

    uart_receiver #(
        .WORD_SIZE (8),
        .CLOCK_FREQ(15),
        .BAUD_RATE (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .rx_read_i     (rx_read_i),
        .data_recv     (data_recv),
        .rx_avbl_o     (rx_avbl_o),
        .rx_frame_err_o(rx_frame_err_o),
        .rx_overrun_o  (rx_overrun_o),
        .rx_busy_o     (rx_busy_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_frame_err_o === 1'b1) ferr_cnt++;
    end

    // Index j: inputs set on the negedge before posedge E+j, where E first sees the start bit.
    // Completion of a good frame happens at posedge E+154.
    task automatic drive_frame(input logic [7:0] data, input logic stop_bit, input int read_j,
                               input int rst_j, input bit glitch,
                               output logic avbl_pre, output logic avbl_post);
        logic [9:0] bits;
        bits      = {1'b0, data, stop_bit};
        avbl_pre  = 1'bx;
        avbl_post = 1'bx;
        for (int j = 0; j < 160; j++) begin
            @(negedge clk);
            if (j == 154) avbl_pre = rx_avbl_o;
            if (j == 155) avbl_post = rx_avbl_o;
            if (j == rst_j) begin
                rst = 1'b1;
                return;
            end
            rx = bits[9 - j / 16];
            if (glitch && (j % 16 == 9)) rx = ~rx;
            rx_read_i = (j == read_j);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx        = 1'b1;
            rx_read_i = 1'b0;
        end
    endtask

    task automatic read_pulse();
        @(negedge clk);
        rx_read_i = 1'b1;
        @(negedge clk);
        rx_read_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rx_read_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (data_recv !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", data_recv); end
        checks++; if (rx_avbl_o !== 1'b0) begin failures++; $display("FAIL reset_avbl: got %b expected 0", rx_avbl_o); end
        checks++; if (rx_frame_err_o !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b expected 0", rx_frame_err_o); end
        checks++; if (rx_overrun_o !== 1'b0) begin failures++; $display("FAIL reset_ovr: got %b expected 0", rx_overrun_o); end
        checks++; if (rx_busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", rx_busy_o); end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_basic();
        logic pre, post;
        logic [7:0] exp;
        exp_q.push_back(8'hA5);
        drive_frame(8'hA5, 1'b1, -1, -1, 1'b0, pre, post);
        idle(4);
        exp = exp_q.pop_front();
        checks++; if (pre !== 1'b0) begin failures++; $display("FAIL basic_lat_pre: avbl %b expected 0", pre); end
        checks++; if (post !== 1'b1) begin failures++; $display("FAIL basic_lat_post: avbl %b expected 1", post); end
        checks++; if (data_recv !== exp) begin failures++; $display("FAIL basic_data: got %h expected %h", data_recv, exp); end
        checks++; if (rx_avbl_o !== 1'b1) begin failures++; $display("FAIL basic_avbl: got %b expected 1", rx_avbl_o); end
        checks++; if (ferr_cnt !== 0) begin failures++; $display("FAIL basic_ferr: pulses %0d expected 0", ferr_cnt); end
        checks++; if (rx_busy_o !== 1'b0) begin failures++; $display("FAIL basic_busy: got %b expected 0", rx_busy_o); end
        read_pulse();
        checks++; if (rx_avbl_o !== 1'b0) begin failures++; $display("FAIL basic_read: avbl %b expected 0", rx_avbl_o); end
    endtask

    task automatic test_start_glitch();
        int busy_cnt = 0;
        logic pre, post;
        logic [7:0] exp;
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            if (rx_busy_o === 1'b1) busy_cnt++;
            rx = (j < 4) ? 1'b0 : 1'b1;
        end
        checks++; if (busy_cnt !== 8) begin failures++; $display("FAIL glitch_busy_cycles: got %0d expected 8", busy_cnt); end
        checks++; if (rx_busy_o !== 1'b0) begin failures++; $display("FAIL glitch_idle: busy %b expected 0", rx_busy_o); end
        checks++; if (data_recv !== 8'hA5) begin failures++; $display("FAIL glitch_data: got %h expected a5", data_recv); end
        checks++; if (rx_avbl_o !== 1'b0) begin failures++; $display("FAIL glitch_avbl: got %b expected 0", rx_avbl_o); end
        exp_q.push_back(8'h3C);
        drive_frame(8'h3C, 1'b1, -1, -1, 1'b0, pre, post);
        idle(4);
        exp = exp_q.pop_front();
        checks++; if (data_recv !== exp) begin failures++; $display("FAIL glitch_next_data: got %h expected %h", data_recv, exp); end
        checks++; if (rx_avbl_o !== 1'b1) begin failures++; $display("FAIL glitch_next_avbl: got %b expected 1", rx_avbl_o); end
        read_pulse();
    endtask

    task automatic test_frame_error();
        int base;
        logic pre, post;
        logic [7:0] exp;
        base = ferr_cnt;
        drive_frame(8'hFF, 1'b0, -1, -1, 1'b0, pre, post);
        repeat (40) begin
            @(negedge clk);
            rx = 1'b0;
        end
        checks++; if (ferr_cnt - base !== 1) begin failures++; $display("FAIL ferr_pulses: got %0d expected 1", ferr_cnt - base); end
        checks++; if (rx_avbl_o !== 1'b0) begin failures++; $display("FAIL ferr_avbl: got %b expected 0", rx_avbl_o); end
        checks++; if (data_recv !== 8'h3C) begin failures++; $display("FAIL ferr_data: got %h expected 3c", data_recv); end
        checks++; if (rx_busy_o !== 1'b1) begin failures++; $display("FAIL ferr_break: busy %b expected 1", rx_busy_o); end
        idle(4);
        checks++; if (rx_busy_o !== 1'b0) begin failures++; $display("FAIL ferr_release: busy %b expected 0", rx_busy_o); end
        exp_q.push_back(8'h81);
        drive_frame(8'h81, 1'b1, -1, -1, 1'b0, pre, post);
        idle(4);
        exp = exp_q.pop_front();
        checks++; if (data_recv !== exp) begin failures++; $display("FAIL ferr_next_data: got %h expected %h", data_recv, exp); end
        checks++; if (rx_avbl_o !== 1'b1) begin failures++; $display("FAIL ferr_next_avbl: got %b expected 1", rx_avbl_o); end
        read_pulse();
    endtask

    task automatic test_overrun();
        logic pre, post;
        logic [7:0] exp;
        exp_q.push_back(8'h11);
        drive_frame(8'h11, 1'b1, -1, -1, 1'b0, pre, post);
        idle(4);
        exp = exp_q.pop_front();
        checks++; if (data_recv !== exp) begin failures++; $display("FAIL ovr_first_data: got %h expected %h", data_recv, exp); end
        checks++; if (rx_overrun_o !== 1'b0) begin failures++; $display("FAIL ovr_first_flag: got %b expected 0", rx_overrun_o); end
        exp_q.push_back(8'h22);
        drive_frame(8'h22, 1'b1, -1, -1, 1'b0, pre, post);
        idle(4);
        exp = exp_q.pop_front();
        checks++; if (data_recv !== exp) begin failures++; $display("FAIL ovr_data: got %h expected %h", data_recv, exp); end
        checks++; if (rx_avbl_o !== 1'b1) begin failures++; $display("FAIL ovr_avbl: got %b expected 1", rx_avbl_o); end
        checks++; if (rx_overrun_o !== 1'b1) begin failures++; $display("FAIL ovr_flag: got %b expected 1", rx_overrun_o); end
        read_pulse();
        checks++; if (rx_avbl_o !== 1'b0) begin failures++; $display("FAIL ovr_read_avbl: got %b expected 0", rx_avbl_o); end
        checks++; if (rx_overrun_o !== 1'b0) begin failures++; $display("FAIL ovr_read_flag: got %b expected 0", rx_overrun_o); end
    endtask

    task automatic test_read_same_cycle();
        logic pre, post;
        logic [7:0] exp;
        exp_q.push_back(8'h11);
        drive_frame(8'h11, 1'b1, -1, -1, 1'b0, pre, post);
        idle(4);
        exp = exp_q.pop_front();
        checks++; if (data_recv !== exp) begin failures++; $display("FAIL same_first_data: got %h expected %h", data_recv, exp); end
        exp_q.push_back(8'h5A);
        drive_frame(8'h5A, 1'b1, 154, -1, 1'b0, pre, post);
        idle(4);
        exp = exp_q.pop_front();
        checks++; if (data_recv !== exp) begin failures++; $display("FAIL same_data: got %h expected %h", data_recv, exp); end
        checks++; if (rx_avbl_o !== 1'b1) begin failures++; $display("FAIL same_avbl: got %b expected 1", rx_avbl_o); end
        checks++; if (rx_overrun_o !== 1'b0) begin failures++; $display("FAIL same_ovr: got %b expected 0", rx_overrun_o); end
    endtask

    task automatic test_reset_midframe();
        logic pre, post;
        logic [7:0] exp;
        drive_frame(8'h96, 1'b1, -1, 88, 1'b0, pre, post);
        @(negedge clk);
        checks++; if (data_recv !== 8'h00) begin failures++; $display("FAIL midrst_data: got %h expected 00", data_recv); end
        checks++; if (rx_avbl_o !== 1'b0) begin failures++; $display("FAIL midrst_avbl: got %b expected 0", rx_avbl_o); end
        checks++; if (rx_busy_o !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", rx_busy_o); end
        checks++; if (rx_overrun_o !== 1'b0) begin failures++; $display("FAIL midrst_ovr: got %b expected 0", rx_overrun_o); end
        rst = 1'b0;
        rx  = 1'b1;
        idle(6);
        exp_q.push_back(8'hC3);
        drive_frame(8'hC3, 1'b1, -1, -1, Glitch, pre, post);
        idle(4);
        exp = exp_q.pop_front();
        checks++; if (data_recv !== exp) begin failures++; $display("FAIL midrst_next_data: got %h expected %h", data_recv, exp); end
        checks++; if (rx_avbl_o !== 1'b1) begin failures++; $display("FAIL midrst_next_avbl: got %b expected 1", rx_avbl_o); end
        checks++; if (ferr_cnt !== 1) begin failures++; $display("FAIL midrst_ferr_total: got %0d expected 1", ferr_cnt); end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_left: got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_start_glitch();
        test_frame_error();
        test_overrun();
        test_read_same_cycle();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
